// File: rtl/sn_pkg.sv
// Shared types and helpers for the spike-network API arbiter.
package sn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sn_state_e;

    // Width of a 1-based neuron index able to hold 0..num_src.
    function automatic int sn_idx_bw(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/sn_rr_pick.sv
// Finds the first set bit of mask_i at or after start_i (1-based), wrapping
// from P_N back to 1. idx_o is 0 when nothing is found.
module sn_rr_pick
    import sn_pkg::*;
#(
    parameter int P_N  = 97,
    parameter int P_BW = sn_idx_bw(P_N)
) (
    input  logic [P_N:1]    mask_i,
    input  logic [P_BW-1:0] start_i,
    output logic            found_o,
    output logic [P_BW-1:0] idx_o
);

    localparam int unsigned N_U = P_N;

    int unsigned pos;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int unsigned k = 0; k < N_U; k++) begin
            pos = 32'(start_i) + k;
            if (pos > N_U) begin
                pos = pos - N_U;
            end
            if (!found_o && mask_i[P_BW'(pos)]) begin
                found_o = 1'b1;
                idx_o   = P_BW'(pos);
            end
        end
    end

endmodule

// File: rtl/sn_api_arb_mc.sv
// Multi-lane API arbiter: snapshots pending spikes on nc_transmit and grants
// up to P_NUM_LANES neurons per cycle until the snapshot drains.
module sn_api_arb_mc
    import sn_pkg::*;
#(
    parameter int P_NUM_SRC   = 97,
    parameter int P_NUM_LANES = 2,
    parameter int P_RR_EN     = 1,
    parameter int P_IDX_BW    = sn_idx_bw(P_NUM_SRC)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 nc_transmit,
    input  logic [P_NUM_SRC:1]                   api_pending,
    output logic [P_NUM_SRC:1]                   api_granted,
    output logic [P_NUM_LANES-1:0]               api_vld,
    output logic [P_NUM_LANES-1:0][P_IDX_BW-1:0] api_bus,
    output logic                                 api_nc_done,
    output logic                                 busy,
    output logic [P_IDX_BW-1:0]                  spike_cnt,
    output logic                                 err_overrun
);

    localparam logic [P_IDX_BW-1:0] IDX_ONE = P_IDX_BW'(1);
    localparam logic [P_IDX_BW-1:0] IDX_MAX = P_IDX_BW'(P_NUM_SRC);

    sn_state_e                            state_q, state_d;
    logic [P_NUM_SRC:1]                   snap_q, snap_d, rest;
    logic [P_NUM_SRC:1]                   gr_q, gr_d;
    logic [P_NUM_LANES-1:0]               vld_q, vld_d, found_w;
    logic [P_NUM_LANES-1:0][P_IDX_BW-1:0] bus_q, bus_d, idx_w;
    logic [P_IDX_BW-1:0]                  rr_q, rr_d, start_ptr;
    logic [P_IDX_BW-1:0]                  cnt_q, cnt_d, used_cnt, last_idx, next_rr;
    logic                                 err_q, err_d;

    assign start_ptr = (P_RR_EN != 0) ? rr_q : IDX_ONE;

    // Each lane searches what earlier lanes left; a shared start pointer keeps
    // lane order identical to the overall priority order.
    for (genvar l = 0; l < P_NUM_LANES; l++) begin : g_lane
        logic [P_NUM_SRC:1]  mask_in, mask_out;
        logic                found;
        logic [P_IDX_BW-1:0] idx;

        if (l == 0) begin : g_first
            assign mask_in = snap_q;
        end else begin : g_chain
            assign mask_in = g_lane[l-1].mask_out;
        end

        sn_rr_pick #(
            .P_N  (P_NUM_SRC),
            .P_BW (P_IDX_BW)
        ) u_pick (
            .mask_i  (mask_in),
            .start_i (start_ptr),
            .found_o (found),
            .idx_o   (idx)
        );

        always_comb begin
            mask_out = mask_in;
            if (found) begin
                mask_out[idx] = 1'b0;
            end
        end

        assign found_w[l] = found;
        assign idx_w[l]   = idx;
    end

    assign rest = g_lane[P_NUM_LANES-1].mask_out;

    always_comb begin
        used_cnt = '0;
        last_idx = rr_q;
        for (int unsigned l = 0; l < P_NUM_LANES; l++) begin
            if (found_w[l]) begin
                used_cnt = used_cnt + IDX_ONE;
                last_idx = idx_w[l];
            end
        end
    end

    assign next_rr = (last_idx == IDX_MAX) ? IDX_ONE : last_idx + IDX_ONE;

    // rr_q advances on every granting cycle; since the snapshot only shrinks,
    // this ends each window with the same pointer as updating on SCAN exit.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (nc_transmit && (state_q != ST_IDLE));
        gr_d    = '0;
        vld_d   = '0;
        bus_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (nc_transmit) begin
                    snap_d  = api_pending;
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (snap_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    snap_d = rest;
                    gr_d   = snap_q & ~rest;
                    vld_d  = found_w;
                    bus_d  = idx_w;
                    cnt_d  = cnt_q + used_cnt;
                    if (P_RR_EN != 0) begin
                        rr_d = next_rr;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            rr_q    <= IDX_ONE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            gr_q    <= '0;
            vld_q   <= '0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            gr_q    <= gr_d;
            vld_q   <= vld_d;
            bus_q   <= bus_d;
        end
    end

    assign api_granted = gr_q;
    assign api_vld     = vld_q;
    assign api_bus     = bus_q;
    assign api_nc_done = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign spike_cnt   = cnt_q;
    assign err_overrun = err_q;

endmodule

// File: tb/tb_sn_api_arb_mc.sv
// Bench for sn_api_arb_mc: a fixed-priority 2-lane instance and a round-robin
// 1-lane instance checked every cycle against a window-schedule model.
module tb_sn_api_arb_mc;

    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic nc_a = 1'b0;
    logic nc_b = 1'b0;
    logic [16:1] pend_a = '0;
    logic [8:1]  pend_b = '0;

    logic [16:1]      gr_a;
    logic [1:0]       vld_a;
    logic [1:0][4:0]  bus_a;
    logic             done_a, busy_a, err_a;
    logic [4:0]       cnt_a;

    logic [8:1]       gr_b;
    logic [0:0]       vld_b;
    logic [0:0][3:0]  bus_b;
    logic             done_b, busy_b, err_b;
    logic [3:0]       cnt_b;

    int checks = 0;
    int errors = 0;
    int p = 0;

    sn_api_arb_mc #(
        .P_NUM_SRC   (16),
        .P_NUM_LANES (2),
        .P_RR_EN     (0)
    ) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .nc_transmit (nc_a),
        .api_pending (pend_a),
        .api_granted (gr_a),
        .api_vld     (vld_a),
        .api_bus     (bus_a),
        .api_nc_done (done_a),
        .busy        (busy_a),
        .spike_cnt   (cnt_a),
        .err_overrun (err_a)
    );

    sn_api_arb_mc #(
        .P_NUM_SRC   (8),
        .P_NUM_LANES (1),
        .P_RR_EN     (1)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .nc_transmit (nc_b),
        .api_pending (pend_b),
        .api_granted (gr_b),
        .api_vld     (vld_b),
        .api_bus     (bus_b),
        .api_nc_done (done_b),
        .busy        (busy_b),
        .spike_cnt   (cnt_b),
        .err_overrun (err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int du, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, du, p, act, exp);
        end
    endtask

    // Expected outputs per DUT, indexed by the number of clock edges seen.
    bit [16:1] e_gr   [2][MAXC];
    bit [1:0]  e_vld  [2][MAXC];
    int        e_b0   [2][MAXC];
    int        e_b1   [2][MAXC];
    bit        e_done [2][MAXC];
    bit        e_busy [2][MAXC];
    bit        e_cset [2][MAXC];
    int        e_cnt  [2][MAXC];
    int        m_rr   [2] = '{1, 1};
    int        m_end  [2] = '{-10, -10};
    bit        m_err  [2] = '{1'b0, 1'b0};
    int        cur_cnt[2] = '{0, 0};

    int        ns_m, nl_m, st_m, n_m, c_m, ix_m, q_m;
    int        order_q[$];
    bit [16:1] snap_m;
    bit        nc_m;

    // Model: on an accepted transmit, lay out the whole window in advance.
    always @(posedge clk) begin
        p++;
        for (int du = 0; du < 2; du++) begin
            if (!rst) begin
                for (int q = p; q < MAXC; q++) begin
                    e_gr[du][q] = '0; e_vld[du][q] = '0; e_b0[du][q] = 0; e_b1[du][q] = 0;
                    e_done[du][q] = 0; e_busy[du][q] = 0; e_cset[du][q] = 0; e_cnt[du][q] = 0;
                end
                m_rr[du] = 1; m_end[du] = -10; m_err[du] = 1'b0; cur_cnt[du] = 0;
            end else begin
                nc_m = (du == 0) ? nc_a : nc_b;
                if (nc_m && (p < m_end[du] + 2)) begin
                    m_err[du] = 1'b1;
                end else if (nc_m) begin
                    ns_m   = (du == 0) ? 16 : 8;
                    nl_m   = (du == 0) ? 2 : 1;
                    st_m   = (du == 0) ? 1 : m_rr[du];
                    snap_m = (du == 0) ? pend_a : {8'h00, pend_b};
                    order_q.delete();
                    for (int k = 0; k < ns_m; k++) begin
                        ix_m = ((st_m - 1 + k) % ns_m) + 1;
                        if (snap_m[ix_m]) order_q.push_back(ix_m);
                    end
                    n_m = order_q.size();
                    c_m = (n_m + nl_m - 1) / nl_m;
                    for (int q = p; q <= p + 1 + c_m; q++) e_busy[du][q] = 1'b1;
                    e_cset[du][p] = 1'b1;
                    e_cnt[du][p]  = 0;
                    for (int j = 0; j < c_m; j++) begin
                        q_m = p + 1 + j;
                        for (int l = 0; l < nl_m; l++) begin
                            if (j * nl_m + l < n_m) begin
                                ix_m = order_q[j * nl_m + l];
                                e_vld[du][q_m][l] = 1'b1;
                                if (l == 0) e_b0[du][q_m] = ix_m;
                                else        e_b1[du][q_m] = ix_m;
                                e_gr[du][q_m][ix_m] = 1'b1;
                            end
                        end
                        e_cset[du][q_m] = 1'b1;
                        e_cnt[du][q_m]  = ((j + 1) * nl_m < n_m) ? (j + 1) * nl_m : n_m;
                    end
                    e_done[du][p + 1 + c_m] = 1'b1;
                    m_end[du] = p + 1 + c_m;
                    if (n_m > 0) m_rr[du] = (order_q[n_m - 1] == ns_m) ? 1 : order_q[n_m - 1] + 1;
                end
            end
        end
    end

    int a_gr, a_vld, a_b0, a_b1, a_done, a_busy, a_cnt, a_err;
    int x_gr, x_vld, x_b0, x_b1, x_done, x_busy, x_err;

    always @(negedge clk) begin
        for (int du = 0; du < 2; du++) begin
            if (du == 0) begin
                a_gr = int'(gr_a); a_vld = int'(vld_a); a_b0 = int'(bus_a[0]); a_b1 = int'(bus_a[1]);
                a_done = int'(done_a); a_busy = int'(busy_a); a_cnt = int'(cnt_a); a_err = int'(err_a);
            end else begin
                a_gr = int'(gr_b); a_vld = int'(vld_b); a_b0 = int'(bus_b[0]); a_b1 = 0;
                a_done = int'(done_b); a_busy = int'(busy_b); a_cnt = int'(cnt_b); a_err = int'(err_b);
            end
            if (!rst) begin
                x_gr = 0; x_vld = 0; x_b0 = 0; x_b1 = 0; x_done = 0; x_busy = 0; x_err = 0;
                cur_cnt[du] = 0;
            end else begin
                if (e_cset[du][p]) cur_cnt[du] = e_cnt[du][p];
                x_gr = int'(e_gr[du][p]); x_vld = int'(e_vld[du][p]);
                x_b0 = e_b0[du][p]; x_b1 = e_b1[du][p];
                x_done = int'(e_done[du][p]); x_busy = int'(e_busy[du][p]); x_err = int'(m_err[du]);
            end
            chk("granted", du, a_gr, x_gr);
            chk("vld", du, a_vld, x_vld);
            chk("bus0", du, a_b0, x_b0);
            if (du == 0) chk("bus1", du, a_b1, x_b1);
            chk("nc_done", du, a_done, x_done);
            chk("busy", du, a_busy, x_busy);
            chk("spike_cnt", du, a_cnt, cur_cnt[du]);
            chk("err_overrun", du, a_err, x_err);
        end
    end

    task automatic pulse(input int du, input logic [16:1] pend);
        @(negedge clk);
        if (du == 0) begin
            pend_a = pend; nc_a = 1'b1;
        end else begin
            pend_b = pend[8:1]; nc_b = 1'b1;
        end
        @(negedge clk);
        nc_a = 1'b0;
        nc_b = 1'b0;
    endtask

    task automatic wait_idle(input int du);
        int n = 0;
        while (((du == 0) ? busy_a : busy_b) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", du, int'((du == 0) ? busy_a : busy_b), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, int'(busy_a), 0);
        chk("rst_cnt", 0, int'(cnt_a), 0);
        chk("rst_vld", 0, int'(vld_a), 0);
        chk("rst_err", 1, int'(err_b), 0);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // fixed priority, two lanes: {3,7,9}
        pulse(0, 16'h0144);
        @(negedge clk);
        chk("l_lane0_a", 0, int'(bus_a[0]), 3);
        chk("l_lane1_a", 0, int'(bus_a[1]), 7);
        chk("l_vld_a", 0, int'(vld_a), 3);
        chk("l_gr_a", 0, int'(gr_a), 'h44);
        @(negedge clk);
        chk("l_lane0_b", 0, int'(bus_a[0]), 9);
        chk("l_lane1_b", 0, int'(bus_a[1]), 0);
        chk("l_vld_b", 0, int'(vld_a), 1);
        @(negedge clk);
        chk("l_done", 0, int'(done_a), 1);
        chk("l_cnt3", 0, int'(cnt_a), 3);
        wait_idle(0);

        // empty snapshot
        pulse(0, 16'h0000);
        chk("l_empty_n0", 0, int'(done_a), 0);
        @(negedge clk);
        chk("l_empty_done", 0, int'(done_a), 1);
        chk("l_empty_vld", 0, int'(vld_a), 0);
        chk("l_empty_cnt", 0, int'(cnt_a), 0);
        wait_idle(0);

        // overrun during SCAN
        pulse(0, 16'h001F);
        @(negedge clk);
        nc_a = 1'b1;
        @(negedge clk);
        nc_a = 1'b0;
        chk("l_ovr_set", 0, int'(err_a), 1);
        wait_idle(0);
        chk("l_ovr_sticky", 0, int'(err_a), 1);
        chk("l_ovr_cnt", 0, int'(cnt_a), 5);

        // pending raised mid-window
        pulse(0, 16'h0003);
        pend_a[4] = 1'b1;
        @(negedge clk);
        chk("l_late_gr", 0, int'(gr_a), 'h3);
        wait_idle(0);
        pulse(0, 16'h0008);
        @(negedge clk);
        chk("l_late_next", 0, int'(gr_a), 'h8);
        wait_idle(0);

        // round robin, one lane
        pulse(1, 16'h0010);
        @(negedge clk);
        chk("l_rr_5", 1, int'(bus_b[0]), 5);
        wait_idle(1);
        pulse(1, 16'h0022);
        @(negedge clk);
        chk("l_rr_6", 1, int'(bus_b[0]), 6);
        @(negedge clk);
        chk("l_rr_2", 1, int'(bus_b[0]), 2);
        wait_idle(1);
        pulse(1, 16'h000F);
        @(negedge clk);
        chk("l_rr_ptr3", 1, int'(bus_b[0]), 3);
        wait_idle(1);
        pulse(1, 16'h0081);
        @(negedge clk);
        chk("l_rr_8", 1, int'(bus_b[0]), 8);
        @(negedge clk);
        chk("l_rr_wrap1", 1, int'(bus_b[0]), 1);
        wait_idle(1);

        // full masks
        pulse(0, 16'hFFFF);
        wait_idle(0);
        chk("l_full_cnt_a", 0, int'(cnt_a), 16);
        pulse(1, 16'h00FF);
        @(negedge clk);
        chk("l_full_first_b", 1, int'(bus_b[0]), 2);
        wait_idle(1);
        chk("l_full_cnt_b", 1, int'(cnt_b), 8);

        // reset mid-SCAN
        pulse(0, 16'h03FF);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("l_rst_busy", 0, int'(busy_a), 0);
        chk("l_rst_vld", 0, int'(vld_a), 0);
        chk("l_rst_gr", 0, int'(gr_a), 0);
        chk("l_rst_cnt", 0, int'(cnt_a), 0);
        chk("l_rst_err", 0, int'(err_a), 0);
        chk("l_rst_done", 0, int'(done_a), 0);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("l_post_rst_idle", 0, int'(busy_a), 0);
        pulse(0, 16'h0002);
        @(negedge clk);
        chk("l_post_rst_gr", 0, int'(bus_a[0]), 2);
        wait_idle(0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
